hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the five-stage RV64I+Zba pipeline.
- Drives the enable and clear inputs of the F/D, D/E, E/M and M/W pipeline registers.
- Generates the ALU operand-forwarding selects for the Execute stage.
- Sequences multi-cycle data-memory waits with a timeout FSM and keeps stall and flush event counters for performance debug.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive wait cycles on one memory access before forced release; legal range 2..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- Rs1_D, Rs2_D  in  5 each  source registers in Decode
- Rs1_E, Rs2_E  in  5 each  source registers in Execute
- Rd_E  in  5  destination register in Execute
- ResultSrc_E  in  2  result select in Execute; 2'b01 = load
- Rd_M  in  5  destination register in Memory
- RegWrite_M  in  1  Memory-stage register-write enable
- Rd_W  in  5  destination register in Writeback
- RegWrite_W  in  1  Writeback-stage register-write enable
- PCSrc_E  in  1  taken branch or jump resolved in Execute
- MemReq_M  in  1  load or store active in Memory
- MemReady_M  in  1  data memory completes the access this cycle
- Stall_F, Stall_D, Stall_E, Stall_M  out  1 each  hold the PC / F-D / D-E / E-M registers
- Flush_D, Flush_E, Flush_W  out  1 each  synchronous clear of F-D, D-E, M-W (inserts a bubble)
- ForwardA_E, ForwardB_E  out  2 each  operand select: 00 register file, 10 from M, 01 from W
- MemErr  out  1  one-cycle pulse on memory timeout
- StallCnt, FlushCnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to RUN; wait counter = 0.
  - StallCnt = FlushCnt = 0; MemErr = 0.
  - All combinational outputs evaluate from inputs; with all inputs at 0 they are all 0.
- Forwarding (combinational, zero latency):
  - ForwardA_E = 10 if RegWrite_M and Rd_M != 0 and Rd_M == Rs1_E.
  - Otherwise ForwardA_E = 01 if RegWrite_W and Rd_W != 0 and Rd_W == Rs1_E.
  - Otherwise ForwardA_E = 00.
  - ForwardB_E follows the same rules on Rs2_E.
  - M always wins over W; x0 is never forwarded.
- Load-use detection (combinational):
  - lwStall = (ResultSrc_E == 01) and Rd_E != 0 and (Rd_E == Rs1_D or Rd_E == Rs2_D).
- Memory wait (combinational): memWait = MemReq_M and not MemReady_M and not timeoutHit.
- FSM states:
  - RUN → WAIT when memWait.
  - WAIT stays in WAIT while memWait and waitCnt < MEM_TIMEOUT-1; waitCnt increments each WAIT cycle.
  - WAIT → RUN when MemReady_M, or when MemReq_M drops.
  - WAIT → RUN when waitCnt == MEM_TIMEOUT-1. timeoutHit is asserted combinationally in that cycle, which releases the pipeline and pulses MemErr in the same cycle.
  - waitCnt clears on every exit from WAIT.
- Output priority, highest first:
  1. memWait:
     - Stall_F, Stall_D, Stall_E, Stall_M = 1 and Flush_W = 1.
     - Flush_D = Flush_E = 0, even if PCSrc_E = 1. The branch is held in E and its flush is issued in the release cycle.
  2. PCSrc_E:
     - Flush_D = Flush_E = 1.
     - Stall_F = Stall_D = 0, even if lwStall = 1; the redirect must proceed.
  3. lwStall: Stall_F = Stall_D = 1 and Flush_E = 1.
  4. Otherwise all stall and flush outputs are 0.
- Counters:
  - StallCnt increments on every cycle with Stall_F = 1.
  - FlushCnt increments on every cycle with Flush_D = 1.
  - Both saturate at all-ones; they do not wrap.
- Reset asserted mid-WAIT aborts the wait immediately. No MemErr is pulsed.
- MemReady_M while MemReq_M = 0 is ignored.

Test Plan:
- Forwarding: RegWrite_M=1, Rd_M=5 and RegWrite_W=1, Rd_W=5 with Rs1_E=5 → ForwardA_E=10. Drop RegWrite_M → 01. Set Rd_M=Rd_W=0 and Rs1_E=0 → 00.
- Load-use: ResultSrc_E=01, Rd_E=7, Rs2_D=7 → Stall_F=Stall_D=Flush_E=1 for exactly that cycle, StallCnt=1. Repeat with Rd_E=0 → no stall.
- Branch beats load-use: PCSrc_E=1 together with the load-use condition → Flush_D=Flush_E=1, Stall_F=0, FlushCnt increments by 1.
- Memory wait: MemReq_M=1 with MemReady_M low for 3 cycles, then high → all four stalls and Flush_W high for 3 cycles, released on cycle 4, StallCnt=3, MemErr never asserted.
- Timeout: MEM_TIMEOUT=4, MemReady_M held 0 → stalls for 3 cycles, then release and one MemErr pulse in cycle 4. Also: PCSrc_E=1 during the wait → Flush_D=Flush_E asserted only in the release cycle.
- Reset mid-WAIT: drop rst_n during the second wait cycle → counters 0, FSM in RUN, no MemErr. Counter saturation with CNT_W=4: 20 stall cycles → StallCnt=15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: register ids, stage
// control bits, memory handshake in; stalls, flushes, forwards and counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1_D, Rs2_D;
  logic [4:0]       Rs1_E, Rs2_E, Rd_E;
  logic [1:0]       ResultSrc_E;
  logic [4:0]       Rd_M;
  logic             RegWrite_M;
  logic [4:0]       Rd_W;
  logic             RegWrite_W;
  logic             PCSrc_E;
  logic             MemReq_M;
  logic             MemReady_M;
  logic             Stall_F, Stall_D, Stall_E, Stall_M;
  logic             Flush_D, Flush_E, Flush_W;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, Rd_M, RegWrite_M,
           Rd_W, RegWrite_W, PCSrc_E, MemReq_M, MemReady_M,
    input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
           ForwardA_E, ForwardB_E, MemErr, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, Rd_M, RegWrite_M,
           Rd_W, RegWrite_W, PCSrc_E, MemReq_M, MemReady_M,
    output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
           ForwardA_E, ForwardB_E, MemErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the five-stage pipeline, with a
// timeout-guarded memory-wait FSM and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state, next_state;
  logic [7:0]       wait_cnt, next_cnt;
  logic             timeout_hit, mem_wait, lw_stall;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wr_m, input logic [4:0] rd_m,
                                         input logic wr_w, input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                          return 2'b00;
  endfunction

  assign hz.ForwardA_E = fwd_sel(hz.Rs1_E, hz.RegWrite_M, hz.Rd_M, hz.RegWrite_W, hz.Rd_W);
  assign hz.ForwardB_E = fwd_sel(hz.Rs2_E, hz.RegWrite_M, hz.Rd_M, hz.RegWrite_W, hz.Rd_W);

  assign lw_stall = (hz.ResultSrc_E == 2'b01) && (hz.Rd_E != 5'd0) &&
                    ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));

  // Ready arriving on the last allowed cycle counts as success, not timeout.
  assign timeout_hit = (state == WAIT) && (wait_cnt == TIMEOUT_LAST) &&
                       hz.MemReq_M && !hz.MemReady_M;
  assign mem_wait    = hz.MemReq_M && !hz.MemReady_M && !timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  // wait_cnt counts stalled cycles already spent, so the entry cycle counts as one.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    case (state)
      RUN: begin
        if (mem_wait) begin
          next_state = WAIT;
          next_cnt   = 8'd1;
        end
      end
      WAIT: begin
        if (mem_wait) begin
          next_cnt = wait_cnt + 8'd1;
        end else begin
          next_state = RUN;
          next_cnt   = 8'd0;
        end
      end
      default: begin
        next_state = RUN;
        next_cnt   = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    mem_err = timeout_hit;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrc_E) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      if (flush_d && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.Stall_F  = stall_f;
  assign hz.Stall_D  = stall_d;
  assign hz.Stall_E  = stall_e;
  assign hz.Stall_M  = stall_m;
  assign hz.Flush_D  = flush_d;
  assign hz.Flush_E  = flush_e;
  assign hz.Flush_W  = flush_w;
  assign hz.MemErr   = mem_err;
  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized plus scenario-driven bench for hazard_ctrl, checked against a
// cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = 15;

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic [1:0] result_src_e;
    logic [4:0] rd_m, rd_w;
    logic       reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready_m;
  } stim_t;

  logic clk;
  logic rst_n;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  stim_t cur;
  int    model_waited;
  int    model_stall_cnt;
  int    model_flush_cnt;
  logic  exp_mem_wait, exp_stall_f, exp_flush_d;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic stim_t zeroStim();
    stim_t s;
    s.rs1_d = 0; s.rs2_d = 0; s.rs1_e = 0; s.rs2_e = 0; s.rd_e = 0;
    s.result_src_e = 0; s.rd_m = 0; s.rd_w = 0;
    s.reg_write_m = 0; s.reg_write_w = 0; s.pc_src_e = 0;
    s.mem_req_m = 0; s.mem_ready_m = 0;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rs1_d = 5'($urandom_range(0, 3)); s.rs2_d = 5'($urandom_range(0, 3));
    s.rs1_e = 5'($urandom_range(0, 3)); s.rs2_e = 5'($urandom_range(0, 3));
    s.rd_e  = 5'($urandom_range(0, 3));
    s.result_src_e = 2'($urandom_range(0, 3));
    s.rd_m = 5'($urandom_range(0, 3)); s.rd_w = 5'($urandom_range(0, 3));
    s.reg_write_m = 1'($urandom_range(0, 1));
    s.reg_write_w = 1'($urandom_range(0, 1));
    s.pc_src_e    = ($urandom_range(0, 4) == 0);
    s.mem_req_m   = ($urandom_range(0, 1) == 1);
    s.mem_ready_m = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    cur = s;
    bus.Rs1_D = s.rs1_d;       bus.Rs2_D = s.rs2_d;
    bus.Rs1_E = s.rs1_e;       bus.Rs2_E = s.rs2_e;
    bus.Rd_E = s.rd_e;         bus.ResultSrc_E = s.result_src_e;
    bus.Rd_M = s.rd_m;         bus.RegWrite_M = s.reg_write_m;
    bus.Rd_W = s.rd_w;         bus.RegWrite_W = s.reg_write_w;
    bus.PCSrc_E = s.pc_src_e;
    bus.MemReq_M = s.mem_req_m;
    bus.MemReady_M = s.mem_ready_m;
    #2;
  endtask

  // Operand source: newest producer wins, x0 never forwards.
  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (cur.reg_write_m && cur.rd_m != 0 && cur.rd_m == rs) return 2'b10;
    if (cur.reg_write_w && cur.rd_w != 0 && cur.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkComb();
    logic timeout, lw;
    logic [6:0] exp_ctl;
    timeout = (model_waited == MEM_TIMEOUT - 1) && cur.mem_req_m && !cur.mem_ready_m;
    exp_mem_wait = cur.mem_req_m && !cur.mem_ready_m && !timeout;
    lw = (cur.result_src_e == 2'b01) && cur.rd_e != 0 &&
         (cur.rd_e == cur.rs1_d || cur.rd_e == cur.rs2_d);
    // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W}
    if (exp_mem_wait)      exp_ctl = 7'b1111001;
    else if (cur.pc_src_e) exp_ctl = 7'b0000110;
    else if (lw)           exp_ctl = 7'b1100010;
    else                   exp_ctl = 7'b0000000;
    exp_stall_f = exp_ctl[6];
    exp_flush_d = exp_ctl[2];
    checkOutput("ctl", {25'd0, bus.Stall_F, bus.Stall_D, bus.Stall_E, bus.Stall_M,
                        bus.Flush_D, bus.Flush_E, bus.Flush_W}, {25'd0, exp_ctl});
    checkOutput("fwdA", {30'd0, bus.ForwardA_E}, {30'd0, fwdModel(cur.rs1_e)});
    checkOutput("fwdB", {30'd0, bus.ForwardB_E}, {30'd0, fwdModel(cur.rs2_e)});
    checkOutput("mem_err", {31'd0, bus.MemErr}, {31'd0, timeout});
  endtask

  task automatic checkCounters();
    checkOutput("stall_cnt", {28'd0, bus.StallCnt}, 32'(model_stall_cnt));
    checkOutput("flush_cnt", {28'd0, bus.FlushCnt}, 32'(model_flush_cnt));
  endtask

  task automatic runCycle(input stim_t s);
    applyStimulus(s);
    checkComb();
    @(posedge clk);
    model_waited = exp_mem_wait ? model_waited + 1 : 0;
    if (exp_stall_f && model_stall_cnt < CNT_MAX) model_stall_cnt++;
    if (exp_flush_d && model_flush_cnt < CNT_MAX) model_flush_cnt++;
    #1;
    checkCounters();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    model_waited = 0;
    model_stall_cnt = 0;
    model_flush_cnt = 0;
    #1;
    checkComb();
    checkCounters();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0;
    applyStimulus(zeroStim());
    doReset();

    s = zeroStim();
    s.reg_write_m = 1; s.rd_m = 5; s.reg_write_w = 1; s.rd_w = 5; s.rs1_e = 5;
    runCycle(s);
    s.reg_write_m = 0;
    runCycle(s);
    s.rd_m = 0; s.rd_w = 0; s.rs1_e = 0;
    runCycle(s);

    s = zeroStim();
    s.result_src_e = 2'b01; s.rd_e = 7; s.rs2_d = 7;
    runCycle(s);
    s.rd_e = 0;
    runCycle(s);

    s = zeroStim();
    s.result_src_e = 2'b01; s.rd_e = 7; s.rs1_d = 7; s.pc_src_e = 1;
    runCycle(s);

    s = zeroStim();
    s.mem_req_m = 1;
    for (int i = 0; i < 3; i++) runCycle(s);
    s.mem_ready_m = 1;
    runCycle(s);

    s = zeroStim();
    s.mem_req_m = 1; s.pc_src_e = 1;
    for (int i = 0; i < 4; i++) runCycle(s);
    runCycle(zeroStim());

    s = zeroStim();
    s.mem_req_m = 1;
    runCycle(s);
    applyStimulus(s);
    doReset();
    runCycle(zeroStim());

    s = zeroStim();
    s.result_src_e = 2'b01; s.rd_e = 3; s.rs1_d = 3;
    for (int i = 0; i < 20; i++) runCycle(s);
    checkOutput("stall_sat", {28'd0, bus.StallCnt}, 32'd15);

    doReset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        applyStimulus(randStim());
        doReset();
      end
      runCycle(randStim());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
